// File: rtl/cmd_pkg.sv
// Shared constants, parameter defaults and FSM state type for the command transmitter.
package cmd_pkg;

    localparam logic [7:0] CMD_RESET = 8'b1000_0000;
    localparam logic [1:0] CMD_CHECK = 2'b10;

    localparam int unsigned BAUD_DIV_DEF   = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned GAP_BITS_DEF   = 2;
    localparam int unsigned HB_PERIOD_DEF  = 2500;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StGap
    } tx_state_e;

    function automatic logic cmd_valid(input logic [7:0] cmd);
        return cmd[7:6] == CMD_CHECK;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small command queue; pushes while full and pops while empty are ignored.
module cmd_fifo
    import cmd_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + (AW + 1)'(1);
        if (do_pop)  rd_d = rd_q + (AW + 1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/cmd_tx_sched.sv
// Keypad command scheduler: check-bit filter, queue, 8N1 UART framing with gap and heartbeat.
module cmd_tx_sched
    import cmd_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = BAUD_DIV_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned GAP_BITS   = GAP_BITS_DEF,
    parameter int unsigned HB_PERIOD  = HB_PERIOD_DEF
) (
    input  logic       clk_10k,
    input  logic       rst_n,
    input  logic [7:0] command,
    input  logic       send,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow,
    output logic       reject,
    output logic [7:0] last_cmd
);

    localparam int unsigned BaudW = $clog2(BAUD_DIV + 1);
    localparam int unsigned HbW   = $clog2(HB_PERIOD + 1);

    localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);
    localparam logic [HbW-1:0]   HbLast   = HbW'(HB_PERIOD - 1);
    localparam logic [7:0]       GapLast  = 8'(GAP_BITS - 1);

    tx_state_e        state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [7:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       last_q, last_d;
    logic [HbW-1:0]   hb_q, hb_d;
    logic             tx_q, tx_d;
    logic             ovf_q, ovf_d;
    logic             rej_q, rej_d;

    logic       cmd_ok;
    logic       push;
    logic       pop;
    logic       q_full;
    logic       q_empty;
    logic [7:0] q_head;
    logic       baud_end;

    assign cmd_ok   = cmd_valid(command);
    assign push     = send && cmd_ok;
    assign baud_end = (baud_q == BaudLast);

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_10k),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (command),
        .pop_i   (pop),
        .data_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // Fullness is sampled before this cycle's pop, so a push into a full queue drops.
    assign ovf_d = push && q_full;
    assign rej_d = send && !cmd_ok;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        hb_d    = hb_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        case (state_q)
            StIdle: begin
                baud_d = '0;
                bit_d  = '0;
                tx_d   = 1'b1;
                if (!q_empty) begin
                    pop     = 1'b1;
                    shift_d = q_head;
                    last_d  = q_head;
                    tx_d    = 1'b0;
                    hb_d    = '0;
                    state_d = StStart;
                end else if (hb_q == HbLast) begin
                    hb_d = '0;
                    // A byte arriving now wins; it is popped on the next cycle instead.
                    if (!push) begin
                        shift_d = last_q;
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end
                end else begin
                    hb_d = hb_q + HbW'(1);
                end
            end

            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end

            StData: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 8'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_d   = bit_q + 8'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end

            StStop: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = (GAP_BITS == 0) ? StIdle : StGap;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end

            StGap: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == GapLast) begin
                        state_d = StIdle;
                    end else begin
                        bit_d = bit_q + 8'd1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_10k or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            last_q  <= CMD_RESET;
            hb_q    <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            hb_q    <= hb_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
            rej_q   <= rej_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = (state_q != StIdle);
    assign fifo_full = q_full;
    assign overflow  = ovf_q;
    assign reject    = rej_q;
    assign last_cmd  = last_q;

endmodule

// File: tb/tb_cmd_tx_sched.sv
// Bench for cmd_tx_sched: frame-level reference model, UART receiver and directed literal checks.
module tb_cmd_tx_sched;

    localparam int BAUD  = 8;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int HB    = 2500;
    localparam int FRAME = (10 + GAP) * BAUD;

    logic       clk_10k = 1'b0;
    logic       rst_n   = 1'b1;
    logic       send    = 1'b0;
    logic [7:0] command = 8'h00;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       overflow;
    logic       reject;
    logic [7:0] last_cmd;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    always #5 clk_10k = ~clk_10k;

    cmd_tx_sched #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH),
        .GAP_BITS   (GAP),
        .HB_PERIOD  (HB)
    ) dut (
        .clk_10k   (clk_10k),
        .rst_n     (rst_n),
        .command   (command),
        .send      (send),
        .tx        (tx),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .reject    (reject),
        .last_cmd  (last_cmd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a byte plus its age in cycles since the start edge.
    logic [7:0] m_q[$];
    logic [7:0] m_last   = 8'h80;
    logic [7:0] m_byte   = 8'h00;
    bit         m_active = 1'b0;
    int         m_age    = 0;
    int         m_hb     = 0;
    bit         m_ovf    = 1'b0;
    bit         m_rej    = 1'b0;

    always @(posedge clk_10k or negedge rst_n) begin
        bit acc;
        bit full_before;
        if (!rst_n) begin
            m_q.delete();
            m_last   = 8'h80;
            m_active = 1'b0;
            m_age    = 0;
            m_hb     = 0;
            m_ovf    = 1'b0;
            m_rej    = 1'b0;
        end else begin
            acc         = send && (command[7:6] == 2'b10);
            full_before = (m_q.size() == DEPTH);
            if (m_active) begin
                m_age++;
                if (m_age == FRAME) m_active = 1'b0;
            end else if (m_q.size() > 0) begin
                m_byte   = m_q.pop_front();
                m_last   = m_byte;
                m_active = 1'b1;
                m_age    = 0;
                m_hb     = 0;
            end else if (m_hb == HB - 1) begin
                m_hb = 0;
                if (!acc) begin
                    m_byte   = m_last;
                    m_active = 1'b1;
                    m_age    = 0;
                end
            end else begin
                m_hb++;
            end
            m_ovf = acc && full_before;
            m_rej = send && !acc;
            if (acc && !full_before) m_q.push_back(command);
        end
    end

    function automatic logic exp_tx();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_age / BAUD;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_byte[idx-1];
        return 1'b1;
    endfunction

    always @(negedge clk_10k) begin
        if (chk_en) begin
            check("tx", 32'(tx), 32'(exp_tx()));
            check("busy", 32'(busy), 32'(m_active));
            check("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("reject", 32'(reject), 32'(m_rej));
            check("last_cmd", 32'(last_cmd), 32'(m_last));
        end
    end

    // Independent UART receiver sampling mid-bit.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh = 8'h00;
    int         rx_cnt = 0;

    always @(negedge clk_10k) begin
        if (!rst_n) begin
            rx_cnt = 0;
        end else if (rx_cnt == 0) begin
            if (tx == 1'b0) rx_cnt = 1;
        end else begin
            rx_cnt++;
            if (rx_cnt >= 12 && rx_cnt <= 68 && ((rx_cnt - 12) % 8) == 0)
                rx_sh[(rx_cnt - 12) / 8] = tx;
            if (rx_cnt == 76) begin
                rx_q.push_back(rx_sh);
                rx_cnt = 0;
            end
        end
    end

    task automatic do_reset(input bit lit);
        @(negedge clk_10k);
        #2 rst_n = 1'b0;
        send = 1'b0;
        #1;
        if (lit) begin
            check("rst_tx", 32'(tx), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_full", 32'(fifo_full), 32'd0);
            check("rst_ovf", 32'(overflow), 32'd0);
            check("rst_rej", 32'(reject), 32'd0);
            check("rst_last", 32'(last_cmd), 32'h80);
        end
        chk_en = 1'b1;
        @(negedge clk_10k);
        @(negedge clk_10k);
        #2 rst_n = 1'b1;
        rx_q.delete();
    endtask

    initial begin
        int         j;
        int         busy_cnt;
        logic       hist [1:100];
        int         bits86 [8];
        logic [7:0] cmds [6];

        bits86 = '{0, 1, 1, 0, 0, 0, 0, 1};
        cmds   = '{8'h81, 8'h92, 8'hA3, 8'hB4, 8'h85, 8'h96};

        // Heartbeat after reset and its repeat.
        do_reset(1'b1);
        for (j = 1; j <= 3000; j++) begin
            @(negedge clk_10k);
            if (busy) break;
        end
        check("hb_first_start", 32'(j), 32'd2500);
        for (j = 1; j <= 200; j++) begin
            @(negedge clk_10k);
            if (!busy) break;
        end
        check("hb_busy_len", 32'(j), 32'd96);
        check("hb_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("hb_rx_byte", 32'(rx_q[0]), 32'h80);
        for (j = 1; j <= 3000; j++) begin
            @(negedge clk_10k);
            if (busy) break;
        end
        check("hb_repeat_gap", 32'(j), 32'd2500);

        // Single 0x86 frame.
        do_reset(1'b0);
        @(negedge clk_10k);
        send = 1'b1;
        command = 8'h86;
        busy_cnt = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk_10k);
            send = 1'b0;
            hist[c] = tx;
            busy_cnt += int'(busy);
        end
        check("tx_before_start", 32'(hist[1]), 32'd1);
        check("start_bit_first", 32'(hist[2]), 32'd0);
        check("start_bit_last", 32'(hist[9]), 32'd0);
        for (int i = 0; i < 8; i++) check("data_bit", 32'(hist[14 + 8 * i]), 32'(bits86[i]));
        check("stop_bit", 32'(hist[78]), 32'd1);
        check("frame_busy_len", 32'(busy_cnt), 32'd96);
        check("last_cmd_86", 32'(last_cmd), 32'h86);
        check("rx_86_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("rx_86", 32'(rx_q[0]), 32'h86);

        // Check-bit reject.
        rx_q.delete();
        @(negedge clk_10k);
        send = 1'b1;
        command = 8'h45;
        @(negedge clk_10k);
        send = 1'b0;
        check("reject_pulse", 32'(reject), 32'd1);
        @(negedge clk_10k);
        check("reject_one_cycle", 32'(reject), 32'd0);
        busy_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_10k);
            busy_cnt += int'(busy);
        end
        check("reject_no_frame", 32'(busy_cnt), 32'd0);
        check("reject_no_rx", 32'(rx_q.size()), 32'd0);

        // Six back-to-back strobes: one popped, four queued, one dropped.
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_10k);
            if (i == 5) begin
                check("full_after_five", 32'(fifo_full), 32'd1);
                check("no_ovf_yet", 32'(overflow), 32'd0);
            end
            send = 1'b1;
            command = cmds[i];
        end
        @(negedge clk_10k);
        send = 1'b0;
        check("overflow_pulse", 32'(overflow), 32'd1);
        repeat (600) @(negedge clk_10k);
        check("burst_rx_count", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (rx_q.size() > i) check("burst_rx_byte", 32'(rx_q[i]), 32'(cmds[i]));

        // Reset during data bit 3 aborts the frame and empties the queue.
        do_reset(1'b0);
        @(negedge clk_10k);
        send = 1'b1;
        command = 8'h9C;
        @(negedge clk_10k);
        command = 8'hA5;
        @(negedge clk_10k);
        send = 1'b0;
        repeat (36) @(negedge clk_10k);
        check("pre_abort_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_full", 32'(fifo_full), 32'd0);
        @(negedge clk_10k);
        #2 rst_n = 1'b1;
        rx_q.delete();
        busy_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_10k);
            busy_cnt += int'(busy);
        end
        check("abort_no_frame", 32'(busy_cnt), 32'd0);
        check("abort_no_rx", 32'(rx_q.size()), 32'd0);

        // Strobe coinciding with heartbeat maturity.
        do_reset(1'b0);
        repeat (2499) @(negedge clk_10k);
        send = 1'b1;
        command = 8'h8A;
        @(negedge clk_10k);
        send = 1'b0;
        check("hb_deferred_idle", 32'(busy), 32'd0);
        @(negedge clk_10k);
        check("hb_send_busy", 32'(busy), 32'd1);
        check("hb_send_last", 32'(last_cmd), 32'h8A);
        repeat (120) @(negedge clk_10k);
        check("hb_send_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("hb_send_rx", 32'(rx_q[0]), 32'h8A);

        // Random traffic, a mid-run reset, then a quiet stretch for heartbeats.
        do_reset(1'b0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_10k);
            send = ($urandom_range(0, 9) == 0);
            command = 8'($urandom);
            if ($urandom_range(0, 3) != 0) command[7:6] = 2'b10;
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                @(negedge clk_10k);
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk_10k);
        send = 1'b0;
        repeat (3000) @(negedge clk_10k);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
